// File: rtl/approx_umul_pipe_pkg.sv
// Shared constants and helpers for the approximate multiplier pipeline.
package approx_mul_pkg;

  localparam int unsigned STAT_CNT_W = 32;
  localparam int unsigned STAT_ERR_W = 48;
  // Widest operand the compensation helper handles.
  localparam int unsigned OPND_MAX_W = 32;

  // Sum of the dropped-row partial products (rows i < k) whose column i+j >= comp_col.
  // Operand bits above the real width are zero, so the loops can span OPND_MAX_W.
  function automatic logic [2*OPND_MAX_W-1:0] comp_term(input logic [OPND_MAX_W-1:0] x,
                                                        input logic [OPND_MAX_W-1:0] y,
                                                        input int unsigned k,
                                                        input int unsigned comp_col);
    logic [2*OPND_MAX_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < OPND_MAX_W; i++) begin
      for (int unsigned j = 0; j < OPND_MAX_W; j++) begin
        if ((i < k) && (i + j >= comp_col) && x[i] && y[j]) begin
          acc = acc + ((2*OPND_MAX_W)'(1) << (i + j));
        end
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/approx_umul_pipe_if.sv
// Operand/result handshake bundle of the approximate multiplier pipeline.
interface approx_umul_pipe_if #(
  parameter int unsigned W = 8
) ();

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           in_exact;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_z;
  logic           out_exact;

  // Master: operand source and result sink.
  modport master (
    output in_valid, in_x, in_y, in_exact, out_ready,
    input  in_ready, out_valid, out_z, out_exact
  );

  // Slave: the multiplier pipeline.
  modport slave (
    input  in_valid, in_x, in_y, in_exact, out_ready,
    output in_ready, out_valid, out_z, out_exact
  );

endinterface

// File: rtl/approx_umul_pipe_core.sv
// Combinational approximate / exact unsigned multiplier.
// Approx: (y * x[W-1:K]) << K plus dropped-row terms at column >= COMP_COL.
// With APPROX_MUL_ERR_STAT_EN the exact product is also exported as o_z_ref.
module approx_umul_core
  import approx_mul_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned K        = 2,
  parameter int unsigned COMP_COL = 7
) (
  input  logic [W-1:0]   i_x,
  input  logic [W-1:0]   i_y,
  input  logic           i_exact,
  output logic [2*W-1:0] o_z
`ifdef APPROX_MUL_ERR_STAT_EN
  ,
  output logic [2*W-1:0] o_z_ref
`endif
);

  localparam int unsigned ZW = 2 * W;

  logic [ZW-1:0] w_a;
  logic [ZW-1:0] w_c;
  logic [ZW-1:0] w_ref;

  assign w_ref = ZW'(i_x) * ZW'(i_y);
  assign w_a   = (ZW'(i_y) * ZW'(i_x >> K)) << K;
  assign w_c   = ZW'(comp_term(OPND_MAX_W'(i_x), OPND_MAX_W'(i_y), K, COMP_COL));

  // A + C never exceeds x*y, so the 2W-bit sum cannot wrap.
  assign o_z = i_exact ? w_ref : (w_a + w_c);

`ifdef APPROX_MUL_ERR_STAT_EN
  assign o_z_ref = w_ref;
`endif

endmodule

// File: rtl/approx_umul_pipe.sv
// Pipelined unsigned approximate multiplier with valid/ready handshake.
// Optional feature: define APPROX_MUL_ERR_STAT_EN to carry the exact product down the
// pipe and accumulate count / absolute-error statistics of delivered approx results.
module approx_umul_pipe
  import approx_mul_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned K        = 2,
  parameter int unsigned COMP_COL = 7,
  parameter int unsigned STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  approx_umul_pipe_if.slave     bus
`ifdef APPROX_MUL_ERR_STAT_EN
  ,
  input  logic                  stat_clr,
  output logic [STAT_CNT_W-1:0] stat_cnt,
  output logic [STAT_ERR_W-1:0] stat_err
`endif
);

  typedef struct packed {
    logic [2*W-1:0] z;
    logic           exact_flag;
`ifdef APPROX_MUL_ERR_STAT_EN
    logic [2*W-1:0] z_ref;
`endif
  } pay_t;

  logic [2*W-1:0]    w_z;
  pay_t              w_in_pay;
  logic [STAGES-1:0] w_ld;
  logic [STAGES-1:0] w_src_v;
  pay_t [STAGES-1:0] w_src_d;
  logic [STAGES-1:0] r_v;
  pay_t [STAGES-1:0] r_d;

`ifdef APPROX_MUL_ERR_STAT_EN
  logic [2*W-1:0] w_z_ref;
`endif

  approx_umul_core #(
    .W        (W),
    .K        (K),
    .COMP_COL (COMP_COL)
  ) u_core (
    .i_x     (bus.in_x),
    .i_y     (bus.in_y),
    .i_exact (bus.in_exact),
    .o_z     (w_z)
`ifdef APPROX_MUL_ERR_STAT_EN
    ,
    .o_z_ref (w_z_ref)
`endif
  );

  // Assemble the stage-0 payload from the core outputs.
  always_comb begin
    w_in_pay            = '0;
    w_in_pay.z          = w_z;
    w_in_pay.exact_flag = bus.in_exact;
`ifdef APPROX_MUL_ERR_STAT_EN
    w_in_pay.z_ref      = w_z_ref;
`endif
  end

  // Stage s may load if the sink takes the tail or any stage from s onward is empty;
  // this is the unrolled form of !v[s] | adv[s+1] and avoids a self-referencing chain.
  always_comb begin
    w_ld = '0;
    for (int s = 0; s < STAGES; s++) begin
      w_ld[s] = bus.out_ready;
      for (int t = s; t < STAGES; t++) begin
        if (!r_v[t]) begin
          w_ld[s] = 1'b1;
        end
      end
    end
  end

  // Per-stage source: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    w_src_v    = '0;
    w_src_d    = '0;
    w_src_v[0] = bus.in_valid;
    w_src_d[0] = w_in_pay;
    for (int s = 1; s < STAGES; s++) begin
      w_src_v[s] = r_v[s-1];
      w_src_d[s] = r_d[s-1];
    end
  end

  // Pipeline registers; data only moves with a valid source so outputs hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_d <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_ld[s]) begin
          r_v[s] <= w_src_v[s];
          if (w_src_v[s]) begin
            r_d[s] <= w_src_d[s];
          end
        end
      end
    end
  end

  assign bus.in_ready  = w_ld[0];
  assign bus.out_valid = r_v[STAGES-1];
  assign bus.out_z     = r_d[STAGES-1].z;
  assign bus.out_exact = r_d[STAGES-1].exact_flag;

`ifdef APPROX_MUL_ERR_STAT_EN
  localparam int unsigned ERR_SUM_W = STAT_ERR_W + 1;

  logic                  w_deliver_apx;
  logic [2*W-1:0]        w_diff;
  logic [ERR_SUM_W-1:0]  w_err_sum;
  logic [STAT_CNT_W-1:0] r_cnt;
  logic [STAT_ERR_W-1:0] r_err;

  assign w_deliver_apx = bus.out_valid & bus.out_ready & ~r_d[STAGES-1].exact_flag;
  assign w_diff        = r_d[STAGES-1].z_ref - r_d[STAGES-1].z;
  assign w_err_sum     = {1'b0, r_err} + ERR_SUM_W'(w_diff);

  // Saturating statistics; clear takes priority over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= '0;
    end else if (stat_clr) begin
      r_cnt <= '0;
      r_err <= '0;
    end else if (w_deliver_apx) begin
      r_cnt <= (&r_cnt) ? r_cnt : (r_cnt + STAT_CNT_W'(1));
      r_err <= w_err_sum[STAT_ERR_W] ? '1 : w_err_sum[STAT_ERR_W-1:0];
    end
  end

  assign stat_cnt = r_cnt;
  assign stat_err = r_err;
`endif

endmodule
